exe_ctrl: RTL and testbench

EXE-stage controller for the 5-stage ARM pipeline. Owns the ID→EXE pipeline register, the architectural status register, branch-flush signalling and the freeze sequencing that holds a load/store in EXE until the SRAM access completes. Sits between the ID stage and the EXE datapath (Val2 generator + ALU); the datapath consumes its registered controls and returns ALU status bits.

---
 rtl/exe_ctrl_pkg.sv | 35 +++
 rtl/sram_wait_counter.sv | 27 ++
 rtl/exe_ctrl.sv | 147 ++++++++++++++
 tb/tb_exe_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/exe_ctrl_pkg.sv
// Shared types and constants for the EXE-stage controller and its datapath.
package exe_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] cmd;
    logic       mem_rd;
    logic       mem_wr;
    logic       wb;
    logic       s;
    logic       b;
    logic [3:0] dest;
  } exe_reg_t;

  localparam exe_reg_t EXE_BUBBLE = '0;

  // ALU command encodings, shared with the EXE datapath
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

endpackage

// File: rtl/sram_wait_counter.sv
// Load/decrement wait counter; decrement saturates at zero and reports it.
module sram_wait_counter
  import exe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/exe_ctrl.sv
// EXE-stage controller: ID->EXE register, status register, branch flush and
// freeze sequencing that holds a memory op in EXE for SRAM_LATENCY cycles.
//
// state | meaning
// RUN   | pipeline advancing; a mem op arriving in EXE starts its SRAM access
// WAIT  | mem op held in EXE; freeze until the wait counter reaches zero
module exe_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int SRAM_LATENCY = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_id_valid,
  input  logic       i_id_hazard,
  input  logic [3:0] i_id_exe_cmd,
  input  logic       i_id_mem_read_en,
  input  logic       i_id_mem_write_en,
  input  logic       i_id_wb_en,
  input  logic       i_id_s,
  input  logic       i_id_b,
  input  logic [3:0] i_id_dest,
  input  logic [3:0] i_alu_status,
  output logic       o_exe_valid,
  output logic [3:0] o_exe_cmd,
  output logic       o_exe_mem_read_en,
  output logic       o_exe_mem_write_en,
  output logic       o_exe_wb_en,
  output logic       o_exe_b,
  output logic [3:0] o_exe_dest,
  output logic [3:0] o_status_reg,
  output logic       o_branch_taken,
  output logic       o_flush_if_id,
  output logic       o_freeze,
  output logic       o_mem_start
);

  // The first EXE cycle is spent in RUN, the last at cnt==0 in WAIT.
  localparam logic [CNT_W-1:0] LOAD_VAL =
    CNT_W'((SRAM_LATENCY >= 2) ? (SRAM_LATENCY - 2) : 0);

  state_t   r_state;
  state_t   w_state_nxt;
  exe_reg_t r_exe;
  exe_reg_t w_id_fields;
  logic [3:0] r_status;
  logic w_mem_op;
  logic w_freeze;
  logic w_mem_start;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_zero;
  logic w_branch_taken;

  sram_wait_counter u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  assign w_mem_op       = r_exe.valid & (r_exe.mem_rd | r_exe.mem_wr) & ~r_exe.b;
  assign w_branch_taken = r_exe.valid & r_exe.b & (r_state == ST_RUN);

  always_comb begin
    w_state_nxt = r_state;
    w_freeze    = 1'b0;
    w_mem_start = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_op) begin
          w_mem_start = 1'b1;
          if (SRAM_LATENCY >= 2) begin
            w_freeze    = 1'b1;
            w_cnt_load  = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!w_cnt_zero) begin
          w_freeze  = 1'b1;
          w_cnt_dec = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // A branch carrying mem enables is still a branch: its mem enables are dropped.
  always_comb begin
    w_id_fields        = EXE_BUBBLE;
    w_id_fields.valid  = 1'b1;
    w_id_fields.cmd    = i_id_exe_cmd;
    w_id_fields.mem_rd = i_id_mem_read_en & ~i_id_b;
    w_id_fields.mem_wr = i_id_mem_write_en & ~i_id_b;
    w_id_fields.wb     = i_id_wb_en;
    w_id_fields.s      = i_id_s;
    w_id_fields.b      = i_id_b;
    w_id_fields.dest   = i_id_dest;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exe <= EXE_BUBBLE;
    end else if (w_freeze) begin
      r_exe <= r_exe;
    end else if (w_branch_taken || i_id_hazard || !i_id_valid) begin
      r_exe <= EXE_BUBBLE;
    end else begin
      r_exe <= w_id_fields;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 4'b0000;
    end else if (r_exe.valid && r_exe.s && !w_freeze) begin
      r_status <= i_alu_status;
    end
  end

  assign o_exe_valid        = r_exe.valid;
  assign o_exe_cmd          = r_exe.cmd;
  assign o_exe_mem_read_en  = r_exe.mem_rd;
  assign o_exe_mem_write_en = r_exe.mem_wr;
  assign o_exe_wb_en        = r_exe.wb;
  assign o_exe_b            = r_exe.b;
  assign o_exe_dest         = r_exe.dest;
  assign o_status_reg       = r_status;
  assign o_branch_taken     = w_branch_taken;
  assign o_flush_if_id      = w_branch_taken;
  assign o_freeze           = w_freeze;
  assign o_mem_start        = w_mem_start;

endmodule

// File: tb/tb_exe_ctrl.sv
// Directed bench for exe_ctrl: one instance at SRAM_LATENCY=6, one at 1.
module tb_exe_ctrl;
  import exe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic i_id_valid, i_id_hazard, i_id_mem_read_en, i_id_mem_write_en;
  logic i_id_wb_en, i_id_s, i_id_b;
  logic [3:0] i_id_exe_cmd, i_id_dest, i_alu_status;

  logic       a_valid, a_rd, a_wr, a_wb, a_b, a_br, a_fl, a_frz, a_ms;
  logic [3:0] a_cmd, a_dest, a_st;
  logic       c_valid, c_rd, c_wr, c_wb, c_b, c_br, c_fl, c_frz, c_ms;
  logic [3:0] c_cmd, c_dest, c_st;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exe_ctrl #(.SRAM_LATENCY(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .i_id_valid(i_id_valid), .i_id_hazard(i_id_hazard), .i_id_exe_cmd(i_id_exe_cmd),
    .i_id_mem_read_en(i_id_mem_read_en), .i_id_mem_write_en(i_id_mem_write_en),
    .i_id_wb_en(i_id_wb_en), .i_id_s(i_id_s), .i_id_b(i_id_b), .i_id_dest(i_id_dest),
    .i_alu_status(i_alu_status),
    .o_exe_valid(a_valid), .o_exe_cmd(a_cmd), .o_exe_mem_read_en(a_rd),
    .o_exe_mem_write_en(a_wr), .o_exe_wb_en(a_wb), .o_exe_b(a_b), .o_exe_dest(a_dest),
    .o_status_reg(a_st), .o_branch_taken(a_br), .o_flush_if_id(a_fl),
    .o_freeze(a_frz), .o_mem_start(a_ms)
  );

  exe_ctrl #(.SRAM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_id_valid(i_id_valid), .i_id_hazard(i_id_hazard), .i_id_exe_cmd(i_id_exe_cmd),
    .i_id_mem_read_en(i_id_mem_read_en), .i_id_mem_write_en(i_id_mem_write_en),
    .i_id_wb_en(i_id_wb_en), .i_id_s(i_id_s), .i_id_b(i_id_b), .i_id_dest(i_id_dest),
    .i_alu_status(i_alu_status),
    .o_exe_valid(c_valid), .o_exe_cmd(c_cmd), .o_exe_mem_read_en(c_rd),
    .o_exe_mem_write_en(c_wr), .o_exe_wb_en(c_wb), .o_exe_b(c_b), .o_exe_dest(c_dest),
    .o_status_reg(c_st), .o_branch_taken(c_br), .o_flush_if_id(c_fl),
    .o_freeze(c_frz), .o_mem_start(c_ms)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [3:0] cmd, input logic rd, input logic wr,
                        input logic wb, input logic s, input logic b, input logic [3:0] dest);
    i_id_valid = v; i_id_exe_cmd = cmd; i_id_mem_read_en = rd; i_id_mem_write_en = wr;
    i_id_wb_en = wb; i_id_s = s; i_id_b = b; i_id_dest = dest;
  endtask

  task automatic id_idle();
    id_set(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_id_hazard = 1'b0;
    i_alu_status = 4'h0;
    id_idle();
    #12;
    chk("rst_all6", {a_valid, a_cmd, a_rd, a_wr, a_wb, a_b, a_dest, a_st, a_br, a_fl, a_frz, a_ms}, 32'h0);
    chk("rst_all1", {c_valid, c_cmd, c_rd, c_wr, c_wb, c_b, c_dest, c_st, c_br, c_fl, c_frz, c_ms}, 32'h0);
    rst_n = 1'b1;
    step();

    // ALU op with S; status follows one edge later, S=0 op leaves it alone
    id_set(1'b1, CMD_ADD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
    i_alu_status = 4'b1010;
    step();
    chk("add_valid", a_valid, 1'b1);
    chk("add_cmd",   a_cmd, CMD_ADD);
    chk("add_dest",  a_dest, 4'd3);
    chk("add_wb",    a_wb, 1'b1);
    chk("add_st0",   a_st, 4'b0000);
    id_set(1'b1, CMD_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
    step();
    chk("status_upd", a_st, 4'b1010);
    chk("sub_cmd",    a_cmd, CMD_SUB);
    id_idle();
    i_alu_status = 4'b0101;
    step();
    chk("status_hold", a_st, 4'b1010);
    chk("idle_bubble", {a_valid, a_cmd, a_dest}, 9'h0);

    // Load at latency 6
    id_set(1'b1, CMD_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
    step();
    id_set(1'b1, CMD_MOV, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("ld_ms%0d", k),  a_ms, (k == 0) ? 1'b1 : 1'b0);
      chk($sformatf("ld_frz%0d", k), a_frz, (k < 5) ? 1'b1 : 1'b0);
      chk($sformatf("ld_rd%0d", k),  {a_valid, a_rd, a_dest}, {1'b1, 1'b1, 4'd7});
      step();
    end
    chk("ld_next", {a_valid, a_rd, a_cmd, a_dest}, {1'b1, 1'b0, CMD_MOV, 4'd9});

    // Branch (with a stray mem enable) flushes; next cycle is a bubble
    id_set(1'b1, CMD_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    step();
    chk("br_taken", a_br, 1'b1);
    chk("br_flush", a_fl, 1'b1);
    chk("br_regs",  {a_valid, a_b, a_rd, a_frz, a_ms}, 5'b11000);
    id_set(1'b1, CMD_ADD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd8);
    i_alu_status = 4'b1111;
    step();
    chk("br_bubble", {a_valid, a_b, a_br, a_fl}, 4'b0000);
    chk("br_status", a_st, 4'b1010);

    // Hazard for two cycles
    id_set(1'b1, CMD_ORR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    i_id_hazard = 1'b1;
    step();
    chk("hz_bub0", a_valid, 1'b0);
    step();
    chk("hz_bub1", a_valid, 1'b0);
    i_id_hazard = 1'b0;
    step();
    chk("hz_go", {a_valid, a_cmd, a_dest}, {1'b1, CMD_ORR, 4'd2});

    // Store frozen in EXE while hazard is raised: hold, bubble only after freeze drops
    id_set(1'b1, CMD_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk("st_ms", a_ms, 1'b1);
    id_set(1'b1, CMD_EOR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    i_id_hazard = 1'b1;
    for (int k = 1; k < 6; k++) begin
      step();
      chk($sformatf("st_hold%0d", k), {a_valid, a_wr}, 2'b11);
      chk($sformatf("st_frz%0d", k), a_frz, (k < 5) ? 1'b1 : 1'b0);
    end
    step();
    chk("st_hz_bub", {a_valid, a_wr}, 2'b00);
    i_id_hazard = 1'b0;
    step();
    chk("st_next", {a_valid, a_cmd, a_dest}, {1'b1, CMD_EOR, 4'd4});

    // Reset in the middle of WAIT
    id_set(1'b1, CMD_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    step();
    id_idle();
    step();
    chk("mrst_frz_pre", a_frz, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_async", {a_valid, a_cmd, a_rd, a_wr, a_wb, a_b, a_dest, a_st, a_br, a_fl, a_frz, a_ms}, 32'h0);
    id_set(1'b1, CMD_MOV, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
    #2 rst_n = 1'b1;
    step();
    chk("mrst_first", {a_valid, a_cmd, a_dest, a_frz}, {1'b1, CMD_MOV, 4'd6, 1'b0});

    // Latency 1: back-to-back load/store, no freeze
    id_set(1'b1, CMD_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    step();
    chk("l1_ld", {c_valid, c_rd, c_ms, c_frz}, 4'b1110);
    id_set(1'b1, CMD_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk("l1_st", {c_valid, c_rd, c_wr, c_ms, c_frz}, 5'b10110);
    id_idle();
    step();
    chk("l1_end", {c_valid, c_ms, c_frz}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
